// File: rtl/gray_pkg.sv
// Shared types for the Gray-code decoder: step direction encoding,
// FSM state type and the default code width.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_t;

    typedef enum logic {
        FIRST = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/gray_decoder_gray2bin.sv
// Combinational Gray-to-binary decode (prefix XOR from the MSB down).
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_decoder.sv
// Gray-code decoder with step-direction tracking, adjacency error flag and
// a one-deep valid/ready output register.
// Optional feature: define GRAY_DEC_WRAP_CNT_EN to add the signed saturating
// net wrap counter (wrap_cnt port).
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH  = GRAY_WIDTH_DEF,
    parameter int WCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  gray_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  bin_out,
    output logic [1:0]        dir_out,
    output logic              step_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_sticky,
    input  logic              clr_err
`ifdef GRAY_DEC_WRAP_CNT_EN
    ,
    output logic signed [WCNT_W-1:0] wrap_cnt
`endif
);

    if (WIDTH < 2 || WIDTH > 16 || WCNT_W < 2) begin : g_bad_param
        $error("gray_decoder: illegal WIDTH/WCNT_W");
    end

    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    dir_t             dir_d;
    logic             err_d;
    logic [WIDTH-1:0] bin_dec;
    logic [WIDTH-1:0] prev_bin;
    logic             accept;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (gray_in),
        .bin  (bin_dec)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FIRST;
        else        state_q <= state_d;
    end

    // Next state plus classification of the incoming sample against prev_bin.
    always_comb begin
        state_d = state_q;
        dir_d   = HOLD;
        err_d   = 1'b0;
        case (state_q)
            FIRST: begin
                if (accept) state_d = TRACK;
            end
            TRACK: begin
                if (bin_dec == prev_bin)                dir_d = HOLD;
                else if (bin_dec == prev_bin + BIN_ONE) dir_d = UP;
                else if (bin_dec == prev_bin - BIN_ONE) dir_d = DOWN;
                else                                    err_d = 1'b1;
            end
            default: state_d = FIRST;
        endcase
    end

    // Output register: load on accept, drop valid after a transfer, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
            dir_out   <= HOLD;
            step_err  <= 1'b0;
            prev_bin  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bin_out   <= bin_dec;
            dir_out   <= dir_d;
            step_err  <= err_d;
            prev_bin  <= bin_dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error: a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n)                err_sticky <= 1'b0;
        else if (accept && err_d)  err_sticky <= 1'b1;
        else if (clr_err)          err_sticky <= 1'b0;
    end

`ifdef GRAY_DEC_WRAP_CNT_EN
    localparam logic signed [WCNT_W-1:0] WCNT_MAX = {1'b0, {(WCNT_W-1){1'b1}}};
    localparam logic signed [WCNT_W-1:0] WCNT_MIN = {1'b1, {(WCNT_W-1){1'b0}}};
    localparam logic signed [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    logic wrap_up, wrap_dn;
    assign wrap_up = accept && (dir_d == UP)   && (prev_bin == BIN_MAX);
    assign wrap_dn = accept && (dir_d == DOWN) && (prev_bin == '0);

    // Net wrap counter, saturating at both signed limits.
    always_ff @(posedge clk) begin
        if (!rst_n)                              wrap_cnt <= '0;
        else if (wrap_up && wrap_cnt != WCNT_MAX) wrap_cnt <= wrap_cnt + WCNT_ONE;
        else if (wrap_dn && wrap_cnt != WCNT_MIN) wrap_cnt <= wrap_cnt - WCNT_ONE;
    end
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed vector table, hand-written
// corner sequences and a randomized stream against a behavioural model.
module tb_gray_decoder;

    localparam int W      = 3;
    localparam int WC     = 8;
    localparam int MASK   = (1 << W) - 1;
    localparam int WC_MAX = (1 << (WC - 1)) - 1;
    localparam int WC_MIN = -(1 << (WC - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gray_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] bin_out;
    logic [1:0]   dir_out;
    logic         step_err;
    logic         out_valid;
    logic         out_ready;
    logic         err_sticky;
    logic         clr_err;
`ifdef GRAY_DEC_WRAP_CNT_EN
    logic signed [WC-1:0] wrap_cnt;
`endif

    gray_decoder #(.WIDTH(W), .WCNT_W(WC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bin_out    (bin_out),
        .dir_out    (dir_out),
        .step_err   (step_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_sticky (err_sticky),
        .clr_err    (clr_err)
`ifdef GRAY_DEC_WRAP_CNT_EN
        ,
        .wrap_cnt   (wrap_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int inv_gray[1 << W];
    bit m_first, m_ovalid, m_err, m_sticky;
    int m_prev, m_bin, m_dir, m_wrap;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap_now();
`ifdef GRAY_DEC_WRAP_CNT_EN
        return int'(wrap_cnt);
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_first = 1; m_prev = 0; m_ovalid = 0; m_bin = 0;
        m_dir = 0; m_err = 0; m_sticky = 0; m_wrap = 0;
    endtask

    // One clock of the model, given this cycle's inputs.
    task automatic model_step(input bit rst, input int g, input bit v,
                              input bit ordy, input bit clr);
        int b, diff;
        bit acc, e;
        if (rst) begin
            model_reset();
            return;
        end
        acc = v && (!m_ovalid || ordy);
        e = 0;
        if (acc) begin
            b = inv_gray[g];
            m_dir = 0;
            if (!m_first) begin
                diff = (b - m_prev) & MASK;
                if (diff == 1) begin
                    m_dir = 1;
                    if (m_prev == MASK && m_wrap < WC_MAX) m_wrap++;
                end else if (diff == MASK) begin
                    m_dir = 2;
                    if (m_prev == 0 && m_wrap > WC_MIN) m_wrap--;
                end else if (diff != 0) begin
                    e = 1;
                end
            end
            m_first = 0; m_prev = b; m_bin = b; m_err = e; m_ovalid = 1;
        end else if (ordy) begin
            m_ovalid = 0;
        end
        if (acc && e)  m_sticky = 1;
        else if (clr)  m_sticky = 0;
    endtask

    // Drive one cycle on the falling edge, check after the rising edge.
    task automatic cycle(input bit rst, input int g, input bit v,
                         input bit ordy, input bit clr);
        @(negedge clk);
        rst_n = !rst; gray_in = W'(g); in_valid = v; out_ready = ordy; clr_err = clr;
        #1;
        check("in_ready", int'(in_ready), int'(!m_ovalid || ordy));
        model_step(rst, g, v, ordy, clr);
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(m_ovalid));
        check("bin_out", int'(bin_out), m_bin);
        check("dir_out", int'(dir_out), m_dir);
        check("step_err", int'(step_err), int'(m_err));
        check("err_sticky", int'(err_sticky), int'(m_sticky));
`ifdef GRAY_DEC_WRAP_CNT_EN
        check("wrap_cnt", wrap_now(), m_wrap);
`endif
    endtask

    function automatic int enc(input int n);
        return (n ^ (n >> 1)) & MASK;
    endfunction

    typedef struct {
        bit          rst;
        logic [2:0]  g;
        logic [2:0]  bin;
        logic [1:0]  dir;
        bit          err;
        bit          wchk;
        int          wexp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int held, cur, r;
        for (int n = 0; n <= MASK; n++) inv_gray[enc(n)] = n;
        model_reset();
        rst_n = 0; gray_in = '0; in_valid = 0; out_ready = 1; clr_err = 0;

        // Ramp forward across the wrap, then a reverse walk from 0.
        vecs.push_back('{1, 3'b000, 3'd0, 2'b00, 0, 0, 0});
        vecs.push_back('{0, 3'b001, 3'd1, 2'b01, 0, 0, 0});
        vecs.push_back('{0, 3'b011, 3'd2, 2'b01, 0, 0, 0});
        vecs.push_back('{0, 3'b010, 3'd3, 2'b01, 0, 0, 0});
        vecs.push_back('{0, 3'b110, 3'd4, 2'b01, 0, 0, 0});
        vecs.push_back('{0, 3'b111, 3'd5, 2'b01, 0, 0, 0});
        vecs.push_back('{0, 3'b101, 3'd6, 2'b01, 0, 0, 0});
        vecs.push_back('{0, 3'b100, 3'd7, 2'b01, 0, 0, 0});
        vecs.push_back('{0, 3'b000, 3'd0, 2'b01, 0, 1, 1});
        vecs.push_back('{1, 3'b000, 3'd0, 2'b00, 0, 0, 0});
        vecs.push_back('{0, 3'b100, 3'd7, 2'b10, 0, 0, 0});
        vecs.push_back('{0, 3'b101, 3'd6, 2'b10, 0, 1, -1});
        vecs.push_back('{1, 3'b001, 3'd1, 2'b00, 0, 0, 0});
        vecs.push_back('{0, 3'b110, 3'd4, 2'b00, 1, 0, 0});

        // Reset state.
        cycle(1, 0, 0, 1, 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_dir_out", int'(dir_out), 0);
        check("rst_step_err", int'(step_err), 0);
        check("rst_err_sticky", int'(err_sticky), 0);
`ifdef GRAY_DEC_WRAP_CNT_EN
        check("rst_wrap_cnt", wrap_now(), 0);
`endif

        // Vector table: a reset row costs one reset cycle before the sample.
        foreach (vecs[i]) begin
            if (vecs[i].rst) cycle(1, 0, 0, 1, 0);
            cycle(0, int'(vecs[i].g), 1, 1, 0);
            check("vec_bin", int'(bin_out), int'(vecs[i].bin));
            check("vec_dir", int'(dir_out), int'(vecs[i].dir));
            check("vec_err", int'(step_err), int'(vecs[i].err));
            check("vec_valid", int'(out_valid), 1);
`ifdef GRAY_DEC_WRAP_CNT_EN
            if (vecs[i].wchk) check("vec_wrap", wrap_now(), vecs[i].wexp);
`endif
        end
        check("err_sticky_set", int'(err_sticky), 1);

        // Clear together with a new error (4 -> 0): set wins; then plain clear.
        cycle(0, 3'b000, 1, 1, 1);
        check("clr_vs_err_step", int'(step_err), 1);
        check("clr_vs_err_sticky", int'(err_sticky), 1);
        cycle(0, 0, 0, 1, 1);
        check("clr_sticky", int'(err_sticky), 0);

        // Backpressure: one sample lands, then three stalled cycles.
        cycle(1, 0, 0, 1, 0);
        cycle(0, enc(2), 1, 0, 0);
        held = int'(bin_out);
        check("bp_first", held, 2);
        for (int k = 0; k < 3; k++) begin
            cycle(0, enc(3 + k), 1, 0, 0);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_hold", int'(bin_out), held);
            check("bp_valid", int'(out_valid), 1);
        end
        // Release: back-to-back accepts, one per cycle.
        for (int k = 3; k < 7; k++) begin
            cycle(0, enc(k), 1, 1, 0);
            check("bp_stream_bin", int'(bin_out), k);
            check("bp_stream_dir", int'(dir_out), 1);
        end

        // Mid-stream reset with output pending, then a non-adjacent sample.
        cycle(0, enc(7), 1, 0, 0);
        cycle(0, enc(0), 1, 1, 0);
        check("mr_pre_valid", int'(out_valid), 1);
        cycle(1, enc(1), 1, 0, 0);
        check("mr_valid", int'(out_valid), 0);
        check("mr_wrap", wrap_now(), 0);
        cycle(0, enc(5), 1, 1, 0);
        check("mr_dir", int'(dir_out), 0);
        check("mr_err", int'(step_err), 0);
        check("mr_bin", int'(bin_out), 5);

        // Saturation: many forward and backward wraps.
        cycle(1, 0, 0, 1, 0);
        for (int k = 0; k < (WC_MAX + 3) * (MASK + 1) + 1; k++)
            cycle(0, enc(k & MASK), 1, 1, 0);
`ifdef GRAY_DEC_WRAP_CNT_EN
        check("sat_max", wrap_now(), WC_MAX);
`endif
        cycle(1, 0, 0, 1, 0);
        for (int k = 0; k < (WC_MAX + 4) * (MASK + 1) + 1; k++)
            cycle(0, enc((-k) & MASK), 1, 1, 0);
`ifdef GRAY_DEC_WRAP_CNT_EN
        check("sat_min", wrap_now(), WC_MIN);
`endif

        // Randomized stream, mostly adjacent steps.
        cycle(1, 0, 0, 1, 0);
        cur = 0;
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       cur = (cur + 1) & MASK;
            else if (r < 7)  cur = (cur - 1) & MASK;
            else if (r == 8) cur = int'($urandom_range(0, MASK));
            cycle($urandom_range(0, 99) == 0, enc(cur),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
